ulpb_tx_queue: RTL and testbench

//  Store-and-forward message queue upstream of the ULPB 32-bit node's TX port. Host pushes words

---
 rtl/ulpb_tx_queue_pkg.sv | 18 +
 rtl/ulpb_tx_ram.sv | 40 ++++
 rtl/ulpb_tx_queue.sv | 181 ++++++++++++++++++
 tb/tb_ulpb_tx_queue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpb_tx_queue_pkg.sv
// Shared types for the ULPB TX store-and-forward queue: FSM state codes and
// the node result decode.
package ulpb_tx_queue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_ACKLO  = 3'd2,
        ST_RESULT = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Both result lines high at once is treated as a failure.
    function automatic logic resp_success(input logic succ, input logic fail);
        return succ & ~fail;
    endfunction

endpackage

// File: rtl/ulpb_tx_ram.sv
// Word storage for the TX queue: one write port, async read of the current word,
// async read of the message-start address, and the last flags of every entry.
module ulpb_tx_ram
    import ulpb_tx_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [DEPTH_LOG2-1:0]        wr_idx_i,
    input  logic                         wr_last_i,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic [DEPTH_LOG2-1:0]        rd_idx_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o,
    input  logic [DEPTH_LOG2-1:0]        start_idx_i,
    output logic [ADDR_WIDTH-1:0]        start_addr_o,
    output logic [(1<<DEPTH_LOG2)-1:0]   last_flags_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH-1:0]      last_q;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            last_q[wr_idx_i] <= wr_last_i;
            addr_q[wr_idx_i] <= wr_addr_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o    = data_q[rd_idx_i];
    assign start_addr_o = addr_q[start_idx_i];
    assign last_flags_o = last_q;

endmodule

// File: rtl/ulpb_tx_queue.sv
// Store-and-forward message queue feeding the ULPB node TX handshake.
// Define ULPB_TX_RETRY_EN to resend a failed message up to MAX_RETRY times.
module ulpb_tx_queue
    import ulpb_tx_queue_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH_LOG2 = 3,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] HOST_ADDR,
    input  logic [DATA_WIDTH-1:0] HOST_WDATA,
    input  logic                  HOST_WLAST,
    input  logic                  HOST_WVALID,
    output logic                  HOST_WREADY,
    output logic                  STAT_VALID,
    output logic                  STAT_SUCC,
    output logic                  ERR_OVF,
    output logic [ADDR_WIDTH-1:0] TX_ADDR,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_PEND,
    output logic                  TX_REQ,
    input  logic                  TX_ACK,
    input  logic                  TX_SUCC,
    input  logic                  TX_FAIL,
    output logic                  TX_RESP_ACK
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
`ifdef ULPB_TX_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    state_e                state_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q, start_q, msg_cnt_q, msg_cnt_d;
    logic [3:0]            retry_cnt_q;
    logic                  last_sent_q, retry_q;
    logic                  tx_req_q, resp_ack_q, stat_valid_q, stat_succ_q, err_ovf_q;

    logic [DEPTH-1:0]      last_flags;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [PW-1:0]         occupancy, next_start, scan_idx;
    logic                  push, full, ovf, have_msg, cur_last, found;
    logic                  resp_seen, resp_succ, retry_now, retire;

    ulpb_tx_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i        (CLK),
        .we_i         (push),
        .wr_idx_i     (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_last_i    (HOST_WLAST),
        .wr_addr_i    (HOST_ADDR),
        .wr_data_i    (HOST_WDATA),
        .rd_idx_i     (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o    (rd_data),
        .start_idx_i  (start_q[DEPTH_LOG2-1:0]),
        .start_addr_o (start_addr),
        .last_flags_o (last_flags)
    );

    // Entries stay owned by the head message until it retires.
    assign occupancy   = wr_ptr_q - start_q;
    assign full        = (occupancy == PW'(DEPTH));
    assign HOST_WREADY = ~full;
    assign push        = HOST_WVALID & ~full;
    assign ovf         = full & (msg_cnt_q == '0);
    assign have_msg    = (msg_cnt_q != '0);
    assign cur_last    = last_flags[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign resp_seen = TX_SUCC | TX_FAIL;
    assign resp_succ = resp_success(TX_SUCC, TX_FAIL);
    assign retry_now = RetryEn && !resp_succ && (32'(retry_cnt_q) < MAX_RETRY);
    assign retire    = (state_q == ST_RESP) && !retry_q;
    assign msg_cnt_d = msg_cnt_q + PW'(push & HOST_WLAST) - PW'(retire);

    // Retire jumps past the head message's last word, skipping any unsent words.
    always_comb begin
        next_start = start_q;
        scan_idx   = start_q;
        found      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = start_q + PW'(i);
            if (!found && last_flags[scan_idx[DEPTH_LOG2-1:0]]) begin
                found      = 1'b1;
                next_start = scan_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            start_q      <= '0;
            msg_cnt_q    <= '0;
            retry_cnt_q  <= '0;
            last_sent_q  <= 1'b0;
            retry_q      <= 1'b0;
            tx_req_q     <= 1'b0;
            resp_ack_q   <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_succ_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            resp_ack_q   <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_succ_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            msg_cnt_q    <= msg_cnt_d;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end else if (ovf) begin
                wr_ptr_q  <= start_q;
                err_ovf_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (have_msg) begin
                        state_q  <= ST_REQ;
                        tx_req_q <= 1'b1;
                    end
                end
                ST_REQ, ST_ACKLO, ST_RESULT: begin
                    if (resp_seen) begin
                        state_q      <= ST_RESP;
                        tx_req_q     <= 1'b0;
                        resp_ack_q   <= 1'b1;
                        stat_valid_q <= !retry_now;
                        stat_succ_q  <= resp_succ;
                        retry_q      <= retry_now;
                    end else if (state_q == ST_REQ && TX_ACK) begin
                        state_q     <= ST_ACKLO;
                        tx_req_q    <= 1'b0;
                        rd_ptr_q    <= rd_ptr_q + PW'(1);
                        last_sent_q <= cur_last;
                    end else if (state_q == ST_ACKLO && !TX_ACK) begin
                        if (last_sent_q) begin
                            state_q <= ST_RESULT;
                        end else begin
                            state_q  <= ST_REQ;
                            tx_req_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    if (retry_q) begin
                        rd_ptr_q    <= start_q;
                        retry_cnt_q <= retry_cnt_q + 4'd1;
                    end else begin
                        rd_ptr_q    <= next_start;
                        start_q     <= next_start;
                        retry_cnt_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign TX_REQ      = tx_req_q;
    assign TX_RESP_ACK = resp_ack_q;
    assign STAT_VALID  = stat_valid_q;
    assign STAT_SUCC   = stat_succ_q;
    assign ERR_OVF     = err_ovf_q;
    assign TX_ADDR     = have_msg ? start_addr : '0;
    assign TX_DATA     = have_msg ? rd_data : '0;
    assign TX_PEND     = have_msg & ~cur_last;

endmodule

// File: tb/tb_ulpb_tx_queue.sv
// Scoreboard bench for ulpb_tx_queue: a node model answers the TX handshake,
// a monitor pops expected words/results whenever the queue presents them.
module tb_ulpb_tx_queue;
    import ulpb_tx_queue_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  HOST_ADDR;
    logic [31:0] HOST_WDATA;
    logic        HOST_WLAST, HOST_WVALID, HOST_WREADY;
    logic        STAT_VALID, STAT_SUCC, ERR_OVF;
    logic [7:0]  TX_ADDR;
    logic [31:0] TX_DATA;
    logic        TX_PEND, TX_REQ, TX_ACK, TX_SUCC, TX_FAIL, TX_RESP_ACK;

    always #5 CLK = ~CLK;

    ulpb_tx_queue #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH_LOG2(3), .MAX_RETRY(2)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA), .HOST_WLAST(HOST_WLAST),
        .HOST_WVALID(HOST_WVALID), .HOST_WREADY(HOST_WREADY),
        .STAT_VALID(STAT_VALID), .STAT_SUCC(STAT_SUCC), .ERR_OVF(ERR_OVF),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
        .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic        p;
    } word_t;

`ifdef ULPB_TX_RETRY_EN
    localparam int SENDS = 3;
`else
    localparam int SENDS = 1;
`endif

    word_t exp_words[$];
    logic  exp_stat[$];
    int    n_tests = 0, n_fail = 0;
    int    resp_cnt = 0, ovf_cnt = 0;
    int    fail_word = -1, word_idx = 0, ack_hold = 0;
    bit    result_fail = 1'b0, chk_reraise = 1'b1;
    logic  prev_resp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic word_t mk(input logic [7:0] a, input logic [31:0] d, input logic p);
        word_t w;
        w.a = a; w.d = d; w.p = p;
        return w;
    endfunction

    task automatic push_word(input logic [7:0] a, input logic [31:0] d, input logic l);
        HOST_ADDR = a; HOST_WDATA = d; HOST_WLAST = l; HOST_WVALID = 1'b1;
        @(negedge CLK);
        HOST_WVALID = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int t = 0; t < 600 && !done; t++) begin
            @(negedge CLK);
            if (exp_words.size() == 0 && exp_stat.size() == 0) done = 1'b1;
        end
        check("drain in time", done, 1);
        repeat (6) @(negedge CLK);
    endtask

    task automatic wait_resp();
        bit seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge CLK);
            if (TX_RESP_ACK) seen = 1'b1;
        end
        check("node sees resp_ack", seen, 1);
        @(posedge CLK);
        #2 TX_SUCC = 1'b0; TX_FAIL = 1'b0;
    endtask

    // Monitor: compare every presented word and status against the scoreboard.
    initial begin
        word_t w;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (TX_REQ && TX_ACK) begin
                    if (exp_words.size() == 0) begin
                        check("unexpected tx word", TX_DATA, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        w = exp_words.pop_front();
                        check("tx addr", TX_ADDR, w.a);
                        check("tx data", TX_DATA, w.d);
                        check("tx pend", TX_PEND, w.p);
                    end
                end
                if (STAT_VALID) begin
                    if (exp_stat.size() == 0) check("unexpected stat", 1, 0);
                    else check("stat succ", STAT_SUCC, exp_stat.pop_front());
                end
                if (TX_RESP_ACK) begin
                    resp_cnt++;
                    check("resp_ack single cycle", prev_resp, 0);
                end
                if (ERR_OVF) ovf_cnt++;
            end
            prev_resp = TX_RESP_ACK;
        end
    end

    // Node model: four-phase REQ/ACK per word, then a held result until RESP_ACK.
    initial begin
        logic pend;
        TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        forever begin
            @(negedge CLK);
            if (TX_REQ && !RESET) begin
                if (word_idx == fail_word) begin
                    @(posedge CLK);
                    #2 TX_FAIL = 1'b1;
                    fail_word = -1;
                    word_idx  = 0;
                    wait_resp();
                end else begin
                    @(posedge CLK);
                    #2 TX_ACK = 1'b1;
                    pend = TX_PEND;
                    for (int t = 0; t < 20; t++) begin
                        @(negedge CLK);
                        if (!TX_REQ) break;
                    end
                    repeat (ack_hold) @(posedge CLK);
                    @(posedge CLK);
                    #2 TX_ACK = 1'b0;
                    if (pend) begin
                        word_idx++;
                        if (chk_reraise) begin
                            @(posedge CLK);
                            @(negedge CLK);
                            check("req re-raised 1 cycle after ack fall", TX_REQ, 1);
                        end
                    end else begin
                        word_idx = 0;
                        repeat (2) @(posedge CLK);
                        #2;
                        if (result_fail) TX_FAIL = 1'b1;
                        else             TX_SUCC = 1'b1;
                        wait_resp();
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_resp, base_ovf, req_seen;
        bit in_acklo;
        RESET = 1'b1; HOST_ADDR = '0; HOST_WDATA = '0; HOST_WLAST = 1'b0; HOST_WVALID = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset tx_req", TX_REQ, 0);
        check("reset host_wready", HOST_WREADY, 1);
        check("reset tx_pend", TX_PEND, 0);
        check("reset stat_valid", STAT_VALID, 0);
        check("reset err_ovf", ERR_OVF, 0);
        check("reset tx_resp_ack", TX_RESP_ACK, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Single-word message, success; TX_REQ two cycles after the push.
        base_resp = resp_cnt;
        exp_words.push_back(mk(8'h12, 32'hDEADBEEF, 1'b0));
        exp_stat.push_back(1'b1);
        push_word(8'h12, 32'hDEADBEEF, 1'b1);
        check("t1 no req 1 cycle after push", TX_REQ, 0);
        @(negedge CLK);
        check("t1 req 2 cycles after push", TX_REQ, 1);
        wait_drain();
        check("t1 resp_ack pulses", resp_cnt - base_resp, 1);
        check("t1 msg_cnt empty", dut.msg_cnt_q, 0);

        // Three-word message; address comes from the first word.
        base_resp = resp_cnt;
        exp_words.push_back(mk(8'h30, 32'h1111_1111, 1'b1));
        exp_words.push_back(mk(8'h30, 32'h2222_2222, 1'b1));
        exp_words.push_back(mk(8'h30, 32'h3333_3333, 1'b0));
        exp_stat.push_back(1'b1);
        push_word(8'h30, 32'h1111_1111, 1'b0);
        push_word(8'h31, 32'h2222_2222, 1'b0);
        push_word(8'h32, 32'h3333_3333, 1'b1);
        wait_drain();
        check("t2 resp_ack pulses", resp_cnt - base_resp, 1);

        // Message longer than storage is discarded.
        base_ovf = ovf_cnt;
        for (int i = 0; i < 8; i++) push_word(8'h40, 32'(i), 1'b0);
        check("t3 wready low when full", HOST_WREADY, 0);
        check("t3 no ovf yet", ERR_OVF, 0);
        HOST_WDATA = 32'h9; HOST_WVALID = 1'b1;
        @(negedge CLK);
        HOST_WVALID = 1'b0;
        check("t3 err_ovf pulse", ERR_OVF, 1);
        check("t3 wready after discard", HOST_WREADY, 1);
        req_seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (TX_REQ) req_seen++;
        end
        check("t3 no tx_req", req_seen, 0);
        check("t3 single ovf pulse", ovf_cnt - base_ovf, 1);

        // Fail on word 2 of a 3-word message; next message starts at its own first word.
        base_resp = resp_cnt;
        fail_word = 1;
        exp_words.push_back(mk(8'h50, 32'hA0, 1'b1));
`ifdef ULPB_TX_RETRY_EN
        exp_words.push_back(mk(8'h50, 32'hA0, 1'b1));
        exp_words.push_back(mk(8'h50, 32'hA1, 1'b1));
        exp_words.push_back(mk(8'h50, 32'hA2, 1'b0));
        exp_stat.push_back(1'b1);
`else
        exp_stat.push_back(1'b0);
`endif
        exp_words.push_back(mk(8'h60, 32'hB0, 1'b0));
        exp_stat.push_back(1'b1);
        push_word(8'h50, 32'hA0, 1'b0);
        push_word(8'h50, 32'hA1, 1'b0);
        push_word(8'h50, 32'hA2, 1'b1);
        push_word(8'h60, 32'hB0, 1'b1);
        wait_drain();
        check("t4 resp_ack pulses", resp_cnt - base_resp, SENDS == 3 ? 3 : 2);

        // Every attempt fails.
        base_resp = resp_cnt;
        result_fail = 1'b1;
        for (int s = 0; s < SENDS; s++) begin
            exp_words.push_back(mk(8'h70, 32'h55, 1'b1));
            exp_words.push_back(mk(8'h70, 32'h66, 1'b0));
        end
        exp_stat.push_back(1'b0);
        push_word(8'h70, 32'h55, 1'b0);
        push_word(8'h70, 32'h66, 1'b1);
        wait_drain();
        result_fail = 1'b0;
        check("t5 resp_ack pulses", resp_cnt - base_resp, SENDS);

        // Reset while waiting for ACK low, with two messages queued.
        chk_reraise = 1'b0;
        ack_hold    = 8;
        exp_words.push_back(mk(8'h80, 32'h77, 1'b1));
        push_word(8'h80, 32'h77, 1'b0);
        push_word(8'h80, 32'h78, 1'b1);
        push_word(8'h90, 32'h79, 1'b1);
        in_acklo = 1'b0;
        for (int t = 0; t < 60 && !in_acklo; t++) begin
            @(negedge CLK);
            if (TX_ACK && !TX_REQ) in_acklo = 1'b1;
        end
        check("t6 reached ack-low wait", in_acklo, 1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("t6 tx_req after reset", TX_REQ, 0);
        check("t6 wready after reset", HOST_WREADY, 1);
        check("t6 msg_cnt after reset", dut.msg_cnt_q, 0);
        check("t6 state idle after reset", dut.state_q == ST_IDLE, 1);
        req_seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (TX_REQ) req_seen++;
        end
        check("t6 nothing sent after reset", req_seen, 0);
        check("words left over", exp_words.size(), 0);
        check("results left over", exp_stat.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
